// File: rtl/qmem_arbiter.sv
// qmem_arbiter: round-robin arbiter sharing one QMEM slave among MN masters.
// A grant is held for the whole transfer. After each ack, err or abort the
// arbiter idles for HOLDOFF cycles. During those cycles the slave's trailing
// ack is ignored and never reaches a master.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; pick the next requester round-robin after rr_ptr
// BUSY  | grant held; slave port muxed from the granted master
// HOLD  | post-transfer gap; s_cs low, slave ack/err ignored
module qmem_arbiter #(
  parameter int QAW     = 32,
  parameter int QDW     = 32,
  parameter int QSW     = QDW/8,
  parameter int MN      = 2,
  parameter int HOLDOFF = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MN-1:0]     m_cs,
  input  logic [MN-1:0]     m_we,
  input  logic [MN*QSW-1:0] m_sel,
  input  logic [MN*QAW-1:0] m_adr,
  input  logic [MN*QDW-1:0] m_dat_w,
  output logic [QDW-1:0]    m_dat_r,
  output logic [MN-1:0]     m_ack,
  output logic [MN-1:0]     m_err,
  output logic              s_cs,
  output logic              s_we,
  output logic [QSW-1:0]    s_sel,
  output logic [QAW-1:0]    s_adr,
  output logic [QDW-1:0]    s_dat_w,
  input  logic [QDW-1:0]    s_dat_r,
  input  logic              s_ack,
  input  logic              s_err,
  output logic [MN-1:0]     gnt
);

  localparam int PW        = (MN > 1) ? $clog2(MN) : 1;
  localparam int HCW       = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int HOLD_LOAD = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [MN-1:0]   gnt_nxt;
  logic [PW-1:0]   rr_ptr, rr_nxt;
  logic [HCW-1:0]  hcnt, hcnt_nxt;
  logic [MN-1:0]   pick_oh;
  logic [PW-1:0]   pick_idx;
  logic            cur_cs;

  // Granted master's own request; dropping it while BUSY is an abort.
  assign cur_cs = |(m_cs & gnt);

  // Round-robin pick: the requester with the smallest distance past rr_ptr wins.
  always_comb begin
    int best_d;
    int d;
    pick_oh  = '0;
    pick_idx = rr_ptr;
    best_d   = MN;
    d        = 0;
    for (int i = 0; i < MN; i++) begin
      d = i - int'(rr_ptr) - 1;
      if (d < 0) d = d + MN;
      if (m_cs[i] && (d < best_d)) begin
        best_d   = d;
        pick_idx = PW'(i);
        pick_oh  = '0;
        pick_oh[i] = 1'b1;
      end
    end
  end

  // State register with grant, rotation pointer and holdoff down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt    <= '0;
      rr_ptr <= PW'(MN - 1);
      hcnt   <= '0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      rr_ptr <= rr_nxt;
      hcnt   <= hcnt_nxt;
    end
  end

  // Next-state logic; the grant is taken in IDLE and released on completion or abort.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    rr_nxt    = rr_ptr;
    hcnt_nxt  = hcnt;
    case (state)
      IDLE: begin
        if (|m_cs) begin
          state_nxt = BUSY;
          gnt_nxt   = pick_oh;
          rr_nxt    = pick_idx;
        end
      end
      BUSY: begin
        if (!cur_cs || s_ack || s_err) begin
          gnt_nxt = '0;
          if (HOLDOFF == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = HOLD;
            hcnt_nxt  = HCW'(HOLD_LOAD);
          end
        end
      end
      HOLD: begin
        if (hcnt == '0) state_nxt = IDLE;
        else            hcnt_nxt  = hcnt - HCW'(1);
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // Output logic: gnt is non-zero only in BUSY, so the AND-OR mux drives zeros otherwise.
  always_comb begin
    s_we    = 1'b0;
    s_sel   = '0;
    s_adr   = '0;
    s_dat_w = '0;
    m_ack   = '0;
    m_err   = '0;
    for (int i = 0; i < MN; i++) begin
      if (gnt[i]) begin
        s_we    = m_we[i];
        s_sel   = m_sel[i*QSW +: QSW];
        s_adr   = m_adr[i*QAW +: QAW];
        s_dat_w = m_dat_w[i*QDW +: QDW];
      end
    end
    s_cs = (state == BUSY) && cur_cs;
    if (state == BUSY) begin
      m_ack = gnt & {MN{s_ack & cur_cs}};
      m_err = gnt & {MN{s_err & cur_cs}};
    end
    m_dat_r = rst_n ? s_dat_r : '0;
  end

endmodule

// File: tb/tb_qmem_arbiter.sv
// tb_qmem_arbiter: directed vector table for a 2-master arbiter plus hand-written
// sequences (write mux, abort, reset mid-transfer, 3-master rotation).
module tb_qmem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 2-master instance
  logic [1:0]  cs2, we2, ack2, err2, gnt2;
  logic [7:0]  sel2;
  logic [63:0] adr2, datw2;
  logic [31:0] datr2, s_datr2, s_adr2, s_datw2;
  logic        s_cs2, s_we2, s_ack2, s_err2;
  logic [3:0]  s_sel2;

  qmem_arbiter #(.MN(2), .HOLDOFF(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .m_cs(cs2), .m_we(we2), .m_sel(sel2), .m_adr(adr2),
    .m_dat_w(datw2), .m_dat_r(datr2), .m_ack(ack2), .m_err(err2), .s_cs(s_cs2),
    .s_we(s_we2), .s_sel(s_sel2), .s_adr(s_adr2), .s_dat_w(s_datw2),
    .s_dat_r(s_datr2), .s_ack(s_ack2), .s_err(s_err2), .gnt(gnt2));

  // 3-master instance
  logic [2:0]  cs3, we3, ack3, err3, gnt3;
  logic [11:0] sel3;
  logic [95:0] adr3, datw3;
  logic [31:0] datr3, s_datr3, s_adr3, s_datw3;
  logic        s_cs3, s_we3, s_ack3, s_err3;
  logic [3:0]  s_sel3;

  qmem_arbiter #(.MN(3), .HOLDOFF(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .m_cs(cs3), .m_we(we3), .m_sel(sel3), .m_adr(adr3),
    .m_dat_w(datw3), .m_dat_r(datr3), .m_ack(ack3), .m_err(err3), .s_cs(s_cs3),
    .s_we(s_we3), .s_sel(s_sel3), .s_adr(s_adr3), .s_dat_w(s_datw3),
    .s_dat_r(s_datr3), .s_ack(s_ack3), .s_err(s_err3), .gnt(gnt3));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  cs;
    logic        ack;
    logic        err;
    logic [31:0] dat;
    logic        scs;
    logic [1:0]  eack;
    logic [1:0]  eerr;
    logic [1:0]  egnt;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [1:0] cs, input logic ack,
                              input logic err, input logic [31:0] dat, input logic scs,
                              input logic [1:0] eack, input logic [1:0] eerr,
                              input logic [1:0] egnt);
    vec_t v;
    v.rst = rst; v.cs = cs; v.ack = ack; v.err = err; v.dat = dat;
    v.scs = scs; v.eack = eack; v.eerr = eerr; v.egnt = egnt;
    return v;
  endfunction

  vec_t tv[29];

  task automatic reset_dut2();
    @(negedge clk);
    rst_n = 1'b0;
    cs2 = '0; s_ack2 = 1'b0; s_err2 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    cs2 = '0; we2 = '0; sel2 = '0; adr2 = '0; datw2 = '0;
    s_datr2 = 32'h0; s_ack2 = 1'b0; s_err2 = 1'b0;
    cs3 = '0; we3 = '0; sel3 = '0; adr3 = '0; datw3 = '0;
    s_datr3 = 32'h0; s_ack3 = 1'b0; s_err3 = 1'b0;

    //              rst cs    ack  err  dat           scs  eack   eerr   egnt
    tv[0]  = mk(1'b0, 2'b00, 1'b0, 1'b0, 32'h12345678, 1'b0, 2'b00, 2'b00, 2'b00);
    tv[1]  = mk(1'b1, 2'b01, 1'b0, 1'b0, 32'h00000000, 1'b0, 2'b00, 2'b00, 2'b00);
    tv[2]  = mk(1'b1, 2'b01, 1'b0, 1'b0, 32'h00000000, 1'b1, 2'b00, 2'b00, 2'b01);
    tv[3]  = mk(1'b1, 2'b01, 1'b0, 1'b0, 32'h00000000, 1'b1, 2'b00, 2'b00, 2'b01);
    tv[4]  = mk(1'b1, 2'b01, 1'b0, 1'b0, 32'h00000000, 1'b1, 2'b00, 2'b00, 2'b01);
    tv[5]  = mk(1'b1, 2'b01, 1'b0, 1'b0, 32'h00000000, 1'b1, 2'b00, 2'b00, 2'b01);
    tv[6]  = mk(1'b1, 2'b01, 1'b1, 1'b0, 32'hCAFEBABE, 1'b1, 2'b01, 2'b00, 2'b01);
    tv[7]  = mk(1'b1, 2'b00, 1'b1, 1'b0, 32'hCAFEBABE, 1'b0, 2'b00, 2'b00, 2'b00);
    tv[8]  = mk(1'b1, 2'b00, 1'b0, 1'b0, 32'h00000000, 1'b0, 2'b00, 2'b00, 2'b00);
    tv[9]  = mk(1'b0, 2'b00, 1'b0, 1'b0, 32'h00000000, 1'b0, 2'b00, 2'b00, 2'b00);
    tv[10] = mk(1'b1, 2'b11, 1'b0, 1'b0, 32'h00000000, 1'b0, 2'b00, 2'b00, 2'b00);
    tv[11] = mk(1'b1, 2'b11, 1'b0, 1'b0, 32'h00000000, 1'b1, 2'b00, 2'b00, 2'b01);
    tv[12] = mk(1'b1, 2'b11, 1'b1, 1'b0, 32'hA5A50001, 1'b1, 2'b01, 2'b00, 2'b01);
    tv[13] = mk(1'b1, 2'b10, 1'b1, 1'b0, 32'hA5A50001, 1'b0, 2'b00, 2'b00, 2'b00);
    tv[14] = mk(1'b1, 2'b10, 1'b0, 1'b0, 32'h00000000, 1'b0, 2'b00, 2'b00, 2'b00);
    tv[15] = mk(1'b1, 2'b10, 1'b0, 1'b0, 32'h00000000, 1'b1, 2'b00, 2'b00, 2'b10);
    tv[16] = mk(1'b1, 2'b10, 1'b1, 1'b0, 32'h5A5A0002, 1'b1, 2'b10, 2'b00, 2'b10);
    tv[17] = mk(1'b1, 2'b00, 1'b0, 1'b0, 32'h00000000, 1'b0, 2'b00, 2'b00, 2'b00);
    tv[18] = mk(1'b1, 2'b00, 1'b0, 1'b0, 32'h00000000, 1'b0, 2'b00, 2'b00, 2'b00);
    tv[19] = mk(1'b1, 2'b01, 1'b0, 1'b0, 32'h00000000, 1'b0, 2'b00, 2'b00, 2'b00);
    tv[20] = mk(1'b1, 2'b01, 1'b0, 1'b0, 32'h00000000, 1'b1, 2'b00, 2'b00, 2'b01);
    tv[21] = mk(1'b1, 2'b01, 1'b0, 1'b1, 32'h00000000, 1'b1, 2'b00, 2'b01, 2'b01);
    tv[22] = mk(1'b1, 2'b00, 1'b0, 1'b1, 32'h00000000, 1'b0, 2'b00, 2'b00, 2'b00);
    tv[23] = mk(1'b1, 2'b00, 1'b0, 1'b0, 32'h00000000, 1'b0, 2'b00, 2'b00, 2'b00);
    tv[24] = mk(1'b1, 2'b10, 1'b0, 1'b0, 32'h00000000, 1'b0, 2'b00, 2'b00, 2'b00);
    tv[25] = mk(1'b1, 2'b10, 1'b0, 1'b0, 32'h00000000, 1'b1, 2'b00, 2'b00, 2'b10);
    tv[26] = mk(1'b1, 2'b00, 1'b1, 1'b0, 32'h00000000, 1'b0, 2'b00, 2'b00, 2'b10);
    tv[27] = mk(1'b1, 2'b00, 1'b0, 1'b0, 32'h00000000, 1'b0, 2'b00, 2'b00, 2'b00);
    tv[28] = mk(1'b1, 2'b00, 1'b0, 1'b0, 32'h00000000, 1'b0, 2'b00, 2'b00, 2'b00);

    // reset state
    #1;
    chk("reset s_cs", 64'(s_cs2), 64'd0);
    chk("reset gnt", 64'(gnt2), 64'd0);
    chk("reset m_ack", 64'(ack2), 64'd0);

    // table: single-master read, two-master order, err path, abort with ack
    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      rst_n = tv[i].rst; cs2 = tv[i].cs; s_ack2 = tv[i].ack; s_err2 = tv[i].err;
      s_datr2 = tv[i].dat;
      #1;
      chk($sformatf("row%0d s_cs", i), 64'(s_cs2), 64'(tv[i].scs));
      chk($sformatf("row%0d m_ack", i), 64'(ack2), 64'(tv[i].eack));
      chk($sformatf("row%0d m_err", i), 64'(err2), 64'(tv[i].eerr));
      chk($sformatf("row%0d gnt", i), 64'(gnt2), 64'(tv[i].egnt));
      chk($sformatf("row%0d m_dat_r", i), 64'(datr2), tv[i].rst ? 64'(tv[i].dat) : 64'd0);
    end

    // master 1 write: slave port carries master 1 fields only
    reset_dut2();
    rst_n = 1'b1;
    we2 = 2'b10;
    sel2 = {4'b0011, 4'b1111};
    adr2 = {32'h00001234, 32'hDEAD0000};
    datw2 = {32'h5555AAAA, 32'h11111111};
    cs2 = 2'b10;
    #1;
    chk("wr idle s_sel", 64'(s_sel2), 64'd0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 3) s_ack2 = 1'b1;
      #1;
      chk($sformatf("wr c%0d s_cs", c), 64'(s_cs2), 64'd1);
      chk($sformatf("wr c%0d s_we", c), 64'(s_we2), 64'd1);
      chk($sformatf("wr c%0d s_sel", c), 64'(s_sel2), 64'h3);
      chk($sformatf("wr c%0d s_adr", c), 64'(s_adr2), 64'h00001234);
      chk($sformatf("wr c%0d s_dat_w", c), 64'(s_datw2), 64'h5555AAAA);
    end
    chk("wr m_ack", 64'(ack2), 64'h2);
    @(negedge clk);
    cs2 = '0; s_ack2 = 1'b0; we2 = '0;

    // abort: master 0 drops cs two cycles into BUSY, master 1 pending
    reset_dut2();
    rst_n = 1'b1;
    cs2 = 2'b11;
    @(negedge clk); #1;
    chk("abort c1 gnt", 64'(gnt2), 64'h1);
    @(negedge clk); #1;
    chk("abort c2 s_cs", 64'(s_cs2), 64'd1);
    @(negedge clk);
    cs2 = 2'b10;
    #1;
    chk("abort c3 s_cs", 64'(s_cs2), 64'd0);
    chk("abort c3 m_ack", 64'(ack2), 64'd0);
    @(negedge clk);
    s_ack2 = 1'b1;
    #1;
    chk("abort hold gnt", 64'(gnt2), 64'd0);
    chk("abort hold m_ack", 64'(ack2), 64'd0);
    @(negedge clk);
    s_ack2 = 1'b0;
    #1;
    chk("abort idle gnt", 64'(gnt2), 64'd0);
    @(negedge clk); #1;
    chk("abort regrant gnt", 64'(gnt2), 64'h2);
    chk("abort regrant s_cs", 64'(s_cs2), 64'd1);

    // reset pulsed mid-BUSY: outputs drop without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst s_cs", 64'(s_cs2), 64'd0);
    chk("async rst gnt", 64'(gnt2), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cs2 = 2'b11;
    #1;
    chk("post rst idle gnt", 64'(gnt2), 64'd0);
    @(negedge clk); #1;
    chk("post rst first gnt", 64'(gnt2), 64'h1);
    cs2 = '0;

    // 3 masters requesting continuously: grants rotate 0,1,2,0,1,2
    cs3 = 3'b111;
    for (int t = 0; t < 6; t++) begin
      found = 1'b0;
      for (int w = 0; w < 10 && !found; w++) begin
        @(negedge clk);
        s_ack3 = 1'b0;
        #1;
        if (gnt3 != '0) found = 1'b1;
      end
      n_chk++;
      if (!found) begin
        n_fail++;
        $display("FAIL rot%0d timeout: got no grant, required a grant within 10 cycles", t);
      end else begin
        chk($sformatf("rot%0d gnt", t), 64'(gnt3), 64'(3'b001 << (t % 3)));
        s_ack3 = 1'b1;
        #1;
        chk($sformatf("rot%0d m_ack", t), 64'(ack3), 64'(3'b001 << (t % 3)));
      end
    end
    @(negedge clk);
    s_ack3 = 1'b0;
    cs3 = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
